// File: rtl/core_sequencer_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: opcodes, datapath control bundle, FSM states.
// decode_ctrl() maps a 7-bit major opcode to its control bundle (unlisted opcodes -> all zero).
package core_sequencer_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_ALUI   = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_ALU    = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_t;

  typedef enum logic {ALU_IN_A_REG, ALU_IN_A_PC} alu_in_a_t;
  typedef enum logic {ALU_IN_B_REG, ALU_IN_B_IMM} alu_in_b_t;
  typedef enum logic {ALU_OP_FROM_ADD, ALU_OP_FROM_OPCODE} alu_op_from_t;
  typedef enum logic [1:0] {
    DEST_REG_FROM_NONE, DEST_REG_FROM_ALU, DEST_REG_FROM_MEM, DEST_REG_FROM_PC
  } dest_reg_from_t;
  typedef enum logic {PC_SRC_NEXT_PC, PC_SRC_ALU} pc_src_t;

  typedef struct packed {
    alu_in_a_t      alu_in_a;
    alu_in_b_t      alu_in_b;
    alu_op_from_t   alu_op_from;
    dest_reg_from_t dest_reg_from;
    pc_src_t        pc_src;
    logic           dbus_re;
    logic           dbus_we;
    logic           en_comp_unit;
  } ins_ctrl_signals_t;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} seq_state_t;

  localparam int CTRL_W = $bits(ins_ctrl_signals_t);

  function automatic ins_ctrl_signals_t decode_ctrl(opcode_t opcode);
    ins_ctrl_signals_t c;
    c = '0;
    case (opcode)
      OPC_ALU: begin
        c.alu_op_from   = ALU_OP_FROM_OPCODE;
        c.dest_reg_from = DEST_REG_FROM_ALU;
      end
      OPC_ALUI: begin
        c.alu_in_b      = ALU_IN_B_IMM;
        c.alu_op_from   = ALU_OP_FROM_OPCODE;
        c.dest_reg_from = DEST_REG_FROM_ALU;
      end
      OPC_LOAD: begin
        c.alu_in_b      = ALU_IN_B_IMM;
        c.dest_reg_from = DEST_REG_FROM_MEM;
        c.dbus_re       = 1'b1;
      end
      OPC_STORE: begin
        c.alu_in_b = ALU_IN_B_IMM;
        c.dbus_we  = 1'b1;
      end
      OPC_BRANCH: begin
        c.alu_in_a     = ALU_IN_A_PC;
        c.alu_in_b     = ALU_IN_B_IMM;
        c.en_comp_unit = 1'b1;
      end
      OPC_JAL: begin
        c.alu_in_a      = ALU_IN_A_PC;
        c.alu_in_b      = ALU_IN_B_IMM;
        c.dest_reg_from = DEST_REG_FROM_PC;
        c.pc_src        = PC_SRC_ALU;
      end
      OPC_JALR: begin
        c.alu_in_b      = ALU_IN_B_IMM;
        c.dest_reg_from = DEST_REG_FROM_PC;
        c.pc_src        = PC_SRC_ALU;
      end
      OPC_LUI: begin
        c.alu_in_b      = ALU_IN_B_IMM;
        c.dest_reg_from = DEST_REG_FROM_ALU;
      end
      OPC_AUIPC: begin
        c.alu_in_a      = ALU_IN_A_PC;
        c.alu_in_b      = ALU_IN_B_IMM;
        c.dest_reg_from = DEST_REG_FROM_ALU;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/core_sequencer_decoder.sv
// Combinational instruction decoder: major opcode -> control bundle, LUI operand override, legality.
module core_decoder
  import core_sequencer_pkg::*;
(
  input  logic [6:0]        opcode,
  output ins_ctrl_signals_t ctrl,
  output logic              rs1_zero,
  output logic              is_legal
);

  always_comb begin
    ctrl     = decode_ctrl(opcode_t'(opcode));
    rs1_zero = (opcode == OPC_LUI);
    is_legal = 1'b0;
    case (opcode_t'(opcode))
      OPC_ALU, OPC_ALUI, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: is_legal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK, HALT on fault.
// Define SEQ_ILLEGAL_TRAP_EN to halt on unlisted opcodes (default: they execute as NOPs).
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ibus_re,
  input  logic              ibus_ready,
  input  logic [31:0]       ibus_rdata,
  input  logic              dbus_ready,
  input  logic              comp_result,
  output ins_ctrl_signals_t ctrl,
  output logic [31:0]       ir,
  output logic              pc_we,
  output logic              reg_we,
  output logic              rs1_zero,
  output logic              halted,
  output logic              bus_err,
  output logic              illegal
);

  localparam int WD_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  seq_state_t        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  ins_ctrl_signals_t ctrl_q, ctrl_d;
  logic              ibus_re_q, ibus_re_d;
  logic              pc_we_q, pc_we_d;
  logic              reg_we_q, reg_we_d;
  logic              rs1_zero_q, rs1_zero_d;
  logic              halted_q, halted_d;
  logic              bus_err_q, bus_err_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

  ins_ctrl_signals_t dec_ctrl;
  logic              dec_rs1_zero;
  logic              dec_is_legal;
  logic              wd_hit;
  logic              wb_reg_we;

  core_decoder u_decoder (
    .opcode   (ir_q[6:0]),
    .ctrl     (dec_ctrl),
    .rs1_zero (dec_rs1_zero),
    .is_legal (dec_is_legal)
  );

  // Expiry fires on the wait cycle that would make the count reach BUS_TIMEOUT.
  assign wd_hit    = (BUS_TIMEOUT != 0) && (wd_cnt_q == WD_W'(BUS_TIMEOUT - 1));
  assign wb_reg_we = (ctrl_q.dest_reg_from != DEST_REG_FROM_NONE) && (ir_q[11:7] != 5'd0);

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ctrl_d     = ctrl_q;
    ibus_re_d  = 1'b0;
    pc_we_d    = 1'b0;
    reg_we_d   = 1'b0;
    rs1_zero_d = rs1_zero_q;
    halted_d   = halted_q;
    bus_err_d  = bus_err_q;
    wd_cnt_d   = wd_cnt_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    case (state_q)
      FETCH: begin
        // ibus_re_q is low for the first FETCH cycle after reset; ready is ignored then.
        if (ibus_re_q && ibus_ready) begin
          ir_d    = ibus_rdata;
          state_d = DECODE;
        end else if (ibus_re_q && wd_hit) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          ibus_re_d = 1'b1;
          if (ibus_re_q) wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      DECODE: begin
        ctrl_d         = dec_is_legal ? dec_ctrl : '0;
        ctrl_d.dbus_re = 1'b0;
        ctrl_d.dbus_we = 1'b0;
        rs1_zero_d     = dec_rs1_zero;
        state_d        = EXECUTE;
`ifdef SEQ_ILLEGAL_TRAP_EN
        if (!dec_is_legal) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end
`endif
      end
      EXECUTE: begin
        if (ctrl_q.en_comp_unit)
          ctrl_d.pc_src = comp_result ? PC_SRC_ALU : PC_SRC_NEXT_PC;
        if (dec_ctrl.dbus_re || dec_ctrl.dbus_we) begin
          state_d        = MEMORY;
          ctrl_d.dbus_re = dec_ctrl.dbus_re;
          ctrl_d.dbus_we = dec_ctrl.dbus_we;
          wd_cnt_d       = '0;
        end else begin
          state_d  = WRITEBACK;
          pc_we_d  = 1'b1;
          reg_we_d = wb_reg_we;
        end
      end
      MEMORY: begin
        if (dbus_ready) begin
          state_d        = WRITEBACK;
          ctrl_d.dbus_re = 1'b0;
          ctrl_d.dbus_we = 1'b0;
          pc_we_d        = 1'b1;
          reg_we_d       = wb_reg_we;
        end else if (wd_hit) begin
          state_d        = HALT;
          halted_d       = 1'b1;
          bus_err_d      = 1'b1;
          ctrl_d.dbus_re = 1'b0;
          ctrl_d.dbus_we = 1'b0;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      WRITEBACK: begin
        state_d   = FETCH;
        ibus_re_d = 1'b1;
        wd_cnt_d  = '0;
      end
      HALT:    ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      ir_q       <= '0;
      ctrl_q     <= '0;
      ibus_re_q  <= 1'b0;
      pc_we_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      rs1_zero_q <= 1'b0;
      halted_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      wd_cnt_q   <= '0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ctrl_q     <= ctrl_d;
      ibus_re_q  <= ibus_re_d;
      pc_we_q    <= pc_we_d;
      reg_we_q   <= reg_we_d;
      rs1_zero_q <= rs1_zero_d;
      halted_q   <= halted_d;
      bus_err_q  <= bus_err_d;
      wd_cnt_q   <= wd_cnt_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  assign ibus_re  = ibus_re_q;
  assign ctrl     = ctrl_q;
  assign ir       = ir_q;
  assign pc_we    = pc_we_q;
  assign reg_we   = reg_we_q;
  assign rs1_zero = rs1_zero_q;
  assign halted   = halted_q;
  assign bus_err  = bus_err_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
  assign illegal  = illegal_q;
`else
  assign illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized instructions checked against a spec-level transaction model.
`timescale 1ns/1ps
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  localparam int unsigned TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ibus_re, ibus_ready, dbus_ready, comp_result;
  logic [31:0]       ibus_rdata, ir;
  ins_ctrl_signals_t ctrl;
  logic              pc_we, reg_we, rs1_zero, halted, bus_err, illegal;

  always #5 clk = ~clk;

  core_sequencer #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ibus_re(ibus_re), .ibus_ready(ibus_ready), .ibus_rdata(ibus_rdata),
    .dbus_ready(dbus_ready), .comp_result(comp_result), .ctrl(ctrl), .ir(ir), .pc_we(pc_we),
    .reg_we(reg_we), .rs1_zero(rs1_zero), .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    int reg_we, rs1_zero, cycles, ire_cnt, re_cnt, we_cnt, pc_cnt, stray, halted, illegal, bus_err;
  } txn_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          fw, dw;
    bit          comp;
    txn_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CTRL_W-1:0] mkc(alu_in_a_t a, alu_in_b_t b, alu_op_from_t op,
                                            dest_reg_from_t d, pc_src_t p, bit cmp);
    ins_ctrl_signals_t c;
    c = '0;
    c.alu_in_a = a; c.alu_in_b = b; c.alu_op_from = op;
    c.dest_reg_from = d; c.pc_src = p; c.en_comp_unit = cmp;
    return c;
  endfunction

  task automatic add_vec(input string nm, input logic [31:0] instr, input int fw, input int dw,
                         input bit comp, input logic [CTRL_W-1:0] c, input int rwe, input int rz,
                         input int cyc, input int re, input int we, input bit halt);
    vec_t v;
    v.name = nm; v.instr = instr; v.fw = fw; v.dw = dw; v.comp = comp;
    v.exp = '{default: 0};
    v.exp.ctrl = c; v.exp.reg_we = rwe; v.exp.rs1_zero = rz; v.exp.cycles = cyc;
    v.exp.ire_cnt = fw + 1; v.exp.re_cnt = re; v.exp.we_cnt = we;
    v.exp.pc_cnt = halt ? 0 : 1; v.exp.halted = halt; v.exp.illegal = halt;
    vecs.push_back(v);
  endtask

  // Reference model: what one instruction should look like from the ports, derived from the decode table.
  function automatic txn_t model(logic [31:0] instr, int fw, int dw, bit comp);
    txn_t e;
    ins_ctrl_signals_t c;
    bit legal, is_ld, is_st;
    e = '{default: 0};
    c = '0; legal = 1; is_ld = 0; is_st = 0;
    case (instr[6:0])
      7'h33: begin c.alu_op_from = ALU_OP_FROM_OPCODE; c.dest_reg_from = DEST_REG_FROM_ALU; end
      7'h13: begin c.alu_in_b = ALU_IN_B_IMM; c.alu_op_from = ALU_OP_FROM_OPCODE;
                   c.dest_reg_from = DEST_REG_FROM_ALU; end
      7'h03: begin c.alu_in_b = ALU_IN_B_IMM; c.dest_reg_from = DEST_REG_FROM_MEM; is_ld = 1; end
      7'h23: begin c.alu_in_b = ALU_IN_B_IMM; is_st = 1; end
      7'h63: begin c.alu_in_a = ALU_IN_A_PC; c.alu_in_b = ALU_IN_B_IMM; c.en_comp_unit = 1'b1;
                   c.pc_src = comp ? PC_SRC_ALU : PC_SRC_NEXT_PC; end
      7'h6F: begin c.alu_in_a = ALU_IN_A_PC; c.alu_in_b = ALU_IN_B_IMM;
                   c.dest_reg_from = DEST_REG_FROM_PC; c.pc_src = PC_SRC_ALU; end
      7'h67: begin c.alu_in_b = ALU_IN_B_IMM; c.dest_reg_from = DEST_REG_FROM_PC; c.pc_src = PC_SRC_ALU; end
      7'h37: begin c.alu_in_b = ALU_IN_B_IMM; c.dest_reg_from = DEST_REG_FROM_ALU; e.rs1_zero = 1; end
      7'h17: begin c.alu_in_a = ALU_IN_A_PC; c.alu_in_b = ALU_IN_B_IMM; c.dest_reg_from = DEST_REG_FROM_ALU; end
      default: legal = 0;
    endcase
    e.ire_cnt = fw + 1;
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (!legal) begin
      e.halted = 1; e.illegal = 1;
      return e;
    end
`endif
    e.ctrl   = c;
    e.pc_cnt = 1;
    e.re_cnt = is_ld ? dw + 1 : 0;
    e.we_cnt = is_st ? dw + 1 : 0;
    e.cycles = 4 + fw + ((is_ld || is_st) ? dw + 1 : 0);
    e.reg_we = (c.dest_reg_from != DEST_REG_FROM_NONE && instr[11:7] != 5'd0) ? 1 : 0;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; ibus_ready = 1'b0; dbus_ready = 1'b0; comp_result = 1'b0; ibus_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one instruction from FETCH until the next FETCH (or HALT), observing the ports each cycle.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int dw, input bit comp,
                           output txn_t o, output bit done);
    int n, wi, wd;
    bit started, seen_pc;
    o = '{default: 0};
    n = 0; wi = 0; wd = 0; started = 0; seen_pc = 0; done = 0;
    for (int k = 0; k < 64; k++) begin
      if (!started && ibus_re) started = 1;
      if (started) n++;
      if (halted || (seen_pc && ibus_re)) begin
        done = 1;
        break;
      end
      if (ibus_re) o.ire_cnt++;
      if (pc_we) begin
        o.pc_cnt++; o.cycles = n; o.ctrl = ctrl; o.reg_we = reg_we; o.rs1_zero = rs1_zero;
        seen_pc = 1;
      end
      if (reg_we && !pc_we) o.stray++;
      if (ctrl.dbus_re) o.re_cnt++;
      if (ctrl.dbus_we) o.we_cnt++;
      if (ibus_re) begin
        ibus_ready = (wi == fw);
        ibus_rdata = (wi == fw) ? instr : $urandom;
        if (wi != fw) wi++;
      end else begin
        ibus_ready = 1'($urandom_range(0, 1));
        ibus_rdata = $urandom;
      end
      if (ctrl.dbus_re || ctrl.dbus_we) begin
        dbus_ready = (wd == dw);
        if (wd != dw) wd++;
      end else begin
        dbus_ready = 1'($urandom_range(0, 1));
      end
      comp_result = comp;
      @(posedge clk); #1;
    end
    o.halted = halted; o.illegal = illegal; o.bus_err = bus_err;
  endtask

  task automatic do_txn(input string nm, input logic [31:0] instr, input int fw, input int dw,
                        input bit comp, input txn_t e);
    txn_t o;
    bit done;
    run_instr(instr, fw, dw, comp, o, done);
    $display("TXN %-8s instr=%08h fw=%0d dw=%0d comp=%0b cycles=%0d reg_we=%0d halted=%0d",
             nm, instr, fw, dw, comp, o.cycles, o.reg_we, o.halted);
    chk({nm, ".done"},     done,       1);
    chk({nm, ".ctrl"},     o.ctrl,     e.ctrl);
    chk({nm, ".reg_we"},   o.reg_we,   e.reg_we);
    chk({nm, ".rs1_zero"}, o.rs1_zero, e.rs1_zero);
    chk({nm, ".cycles"},   o.cycles,   e.cycles);
    chk({nm, ".ibus_re"},  o.ire_cnt,  e.ire_cnt);
    chk({nm, ".dbus_re"},  o.re_cnt,   e.re_cnt);
    chk({nm, ".dbus_we"},  o.we_cnt,   e.we_cnt);
    chk({nm, ".pc_we"},    o.pc_cnt,   e.pc_cnt);
    chk({nm, ".stray"},    o.stray,    0);
    chk({nm, ".halted"},   o.halted,   e.halted);
    chk({nm, ".illegal"},  o.illegal,  e.illegal);
    chk({nm, ".bus_err"},  o.bus_err,  e.bus_err);
    if (o.halted != 0 || !done) do_reset();
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".ibus_re"}, ibus_re, 0);
    chk({nm, ".ctrl"},    ctrl, 0);
    chk({nm, ".ir"},      ir, 0);
    chk({nm, ".pc_we"},   pc_we, 0);
    chk({nm, ".reg_we"},  reg_we, 0);
    chk({nm, ".flags"},   {rs1_zero, halted, bus_err, illegal}, 0);
  endtask

  localparam logic [31:0] I_ADDI  = {12'd7, 5'd1, 3'd0, 5'd5, 7'h13};
  localparam logic [31:0] I_ADDI0 = {12'd7, 5'd1, 3'd0, 5'd0, 7'h13};
  localparam logic [31:0] I_LW    = {12'd4, 5'd2, 3'd2, 5'd3, 7'h03};
  localparam logic [31:0] I_SW    = {7'd0, 5'd3, 5'd2, 3'd2, 5'd8, 7'h23};
  localparam logic [31:0] I_BEQ   = {7'd0, 5'd2, 5'd1, 3'd0, 5'd8, 7'h63};
  localparam logic [31:0] I_LUI   = {20'h12345, 5'd7, 7'h37};
  localparam logic [31:0] I_JAL   = {20'h00100, 5'd1, 7'h6F};
  localparam logic [31:0] I_JALR  = {12'd0, 5'd5, 3'd0, 5'd1, 7'h67};
  localparam logic [31:0] I_AUIPC = {20'h00001, 5'd9, 7'h17};
  localparam logic [31:0] I_ADD   = {7'd0, 5'd2, 5'd1, 3'd0, 5'd10, 7'h33};
  localparam logic [31:0] I_ILL   = {20'h0, 5'd4, 7'h7F};

  initial begin
    txn_t e;
    logic [6:0] ops [10];
    int cnt;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    add_vec("ADDI",   I_ADDI,  0, 0, 0, mkc(ALU_IN_A_REG, ALU_IN_B_IMM, ALU_OP_FROM_OPCODE, DEST_REG_FROM_ALU, PC_SRC_NEXT_PC, 0), 1, 0, 4, 0, 0, 0);
    add_vec("ADDI_X0", I_ADDI0, 0, 0, 0, mkc(ALU_IN_A_REG, ALU_IN_B_IMM, ALU_OP_FROM_OPCODE, DEST_REG_FROM_ALU, PC_SRC_NEXT_PC, 0), 0, 0, 4, 0, 0, 0);
    add_vec("LW",     I_LW,    0, 3, 0, mkc(ALU_IN_A_REG, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_MEM, PC_SRC_NEXT_PC, 0), 1, 0, 8, 4, 0, 0);
    add_vec("BEQ_T",  I_BEQ,   0, 0, 1, mkc(ALU_IN_A_PC, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_NONE, PC_SRC_ALU, 1), 0, 0, 4, 0, 0, 0);
    add_vec("BEQ_NT", I_BEQ,   0, 0, 0, mkc(ALU_IN_A_PC, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_NONE, PC_SRC_NEXT_PC, 1), 0, 0, 4, 0, 0, 0);
    add_vec("SW",     I_SW,    2, 0, 0, mkc(ALU_IN_A_REG, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_NONE, PC_SRC_NEXT_PC, 0), 0, 0, 7, 0, 1, 0);
    add_vec("LUI",    I_LUI,   0, 0, 0, mkc(ALU_IN_A_REG, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_ALU, PC_SRC_NEXT_PC, 0), 1, 1, 4, 0, 0, 0);
    add_vec("JAL",    I_JAL,   1, 0, 0, mkc(ALU_IN_A_PC, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_PC, PC_SRC_ALU, 0), 1, 0, 5, 0, 0, 0);
    add_vec("JALR",   I_JALR,  0, 0, 0, mkc(ALU_IN_A_REG, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_PC, PC_SRC_ALU, 0), 1, 0, 4, 0, 0, 0);
    add_vec("AUIPC",  I_AUIPC, 0, 0, 0, mkc(ALU_IN_A_PC, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_ALU, PC_SRC_NEXT_PC, 0), 1, 0, 4, 0, 0, 0);
    add_vec("ADD_W3", I_ADD,   3, 0, 0, mkc(ALU_IN_A_REG, ALU_IN_B_REG, ALU_OP_FROM_OPCODE, DEST_REG_FROM_ALU, PC_SRC_NEXT_PC, 0), 1, 0, 7, 0, 0, 0);
`ifdef SEQ_ILLEGAL_TRAP_EN
    add_vec("ILL7F",  I_ILL,   0, 0, 0, '0, 0, 0, 0, 0, 0, 1);
`else
    add_vec("ILL7F",  I_ILL,   0, 0, 0, '0, 0, 0, 4, 0, 0, 0);
`endif
    add_vec("LW_W2",  I_LW,    1, 2, 0, mkc(ALU_IN_A_REG, ALU_IN_B_IMM, ALU_OP_FROM_ADD, DEST_REG_FROM_MEM, PC_SRC_NEXT_PC, 0), 1, 0, 8, 3, 0, 0);

    rst = 1'b1;
    do_reset();
    chk_reset_state("reset");

    foreach (vecs[i]) do_txn(vecs[i].name, vecs[i].instr, vecs[i].fw, vecs[i].dw, vecs[i].comp, vecs[i].exp);

    // Reset in the second MEMORY cycle of a store, coinciding with dbus_ready: reset must win.
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 2; k++) begin
      if (ctrl.dbus_we) cnt++;
      if (cnt < 2) begin
        ibus_ready = ibus_re; ibus_rdata = I_SW; dbus_ready = 1'b0;
        @(posedge clk); #1;
      end
    end
    chk("rst_mem.reached", cnt, 2);
    rst = 1'b1; dbus_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dbus_ready = 1'b0;
    $display("TXN RST_MEM  dbus_we=%0b pc_we=%0b ibus_re=%0b", ctrl.dbus_we, pc_we, ibus_re);
    chk("rst_mem.dbus_we", ctrl.dbus_we, 0);
    chk_reset_state("rst_mem");
    @(posedge clk); #1;
    chk("rst_mem.fetch", ibus_re, 1);
    do_txn("ADDI_RC", I_ADDI, 0, 0, 0, model(I_ADDI, 0, 0, 0));

    // Data-bus watchdog: LW whose dbus_ready never comes.
    e = '{default: 0};
    e.ire_cnt = 1; e.re_cnt = TO; e.halted = 1; e.bus_err = 1;
    do_txn("LW_DTO", I_LW, 0, 1000, 0, e);

    // Instruction-bus watchdog: ibus_ready never comes; HALT must then be absorbing.
    e = '{default: 0};
    e.ire_cnt = TO; e.halted = 1; e.bus_err = 1;
    begin
      txn_t o;
      bit done;
      run_instr(I_ADDI, 1000, 0, 0, o, done);
      $display("TXN IBUS_TO  ibus_re_cycles=%0d halted=%0d bus_err=%0d", o.ire_cnt, o.halted, o.bus_err);
      chk("ito.ibus_re", o.ire_cnt, e.ire_cnt);
      chk("ito.halted",  o.halted,  e.halted);
      chk("ito.bus_err", o.bus_err, e.bus_err);
      chk("ito.pc_we",   o.pc_cnt,  0);
      for (int k = 0; k < 4; k++) begin
        ibus_ready = 1'b1; dbus_ready = 1'b1; ibus_rdata = I_ADDI;
        @(posedge clk); #1;
        chk("ito.absorb", {halted, ibus_re, pc_we, bus_err}, 4'b1001);
      end
      do_reset();
    end

    for (int t = 0; t < 80; t++) begin
      logic [31:0] r, instr;
      logic [4:0] rd;
      int fw, dw;
      bit comp;
      r    = $urandom;
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : r[11:7];
      instr = {r[31:12], rd, ops[$urandom_range(0, 9)]};
      fw   = $urandom_range(0, TO - 1);
      dw   = $urandom_range(0, TO - 1);
      comp = 1'($urandom_range(0, 1));
      do_txn("RAND", instr, fw, dw, comp, model(instr, fw, dw, comp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
